// File: rtl/store_lane_aligner.sv
// Store-path aligner: turns {addr, right-justified data, size} into lane-aligned
// DW-bit write beats with byte strobes; boundary-crossing stores become two beats
// or an error pulse. Ports: req_* (valid/ready in), mem_* (registered valid/ready out),
// err_valid/err_addr (reject report), busy (state != IDLE).
// Latency: accept at edge N -> beat/error visible in cycle N+1; outputs held under backpressure.
module store_lane_aligner #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_data,
    input  logic [1:0]      req_size,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_we,
    output logic            err_valid,
    output logic [AW-1:0]   err_addr,
    output logic            busy
);
    localparam int NB = DW / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ERR} state_t;
    state_t state, state_nxt;

    logic [OB-1:0]   off;
    logic [31:0]     nbytes;
    logic [NB-1:0]   bmask;
    logic [DW-1:0]   dmask;
    logic [2*DW-1:0] ext;
    logic [2*NB-1:0] s;
    logic [AW-1:0]   base;
    logic            split;
    logic            illegal;
    logic            accept;
    logic            hs;

    // Second beat is computed at accept time and parked here until beat0 retires.
    logic [AW-1:0]   b1_addr;
    logic [DW-1:0]   b1_data;
    logic [NB-1:0]   b1_we;
    logic            split_q;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign err_valid = (state == ERR);
    assign accept    = req_valid && req_ready;
    assign hs        = mem_valid && mem_ready;

    always_comb begin
        bmask  = '0;
        dmask  = '0;
        off    = req_addr[OB-1:0];
        nbytes = 32'd1 << req_size;
        // Keep only the low nbytes of the store data so unstrobed lanes stay zero.
        for (int i = 0; i < NB; i++) begin
            bmask[i]       = (i < nbytes);
            dmask[8*i +: 8] = bmask[i] ? req_data[8*i +: 8] : 8'h00;
        end
        // Double-width vectors: the upper half is whatever spills into the next word.
        ext     = {{DW{1'b0}}, dmask} << {off, 3'b000};
        s       = {{NB{1'b0}}, bmask} << off;
        base    = {req_addr[AW-1:OB], {OB{1'b0}}};
        split   = |s[2*NB-1:NB];
        illegal = (nbytes > NB) || (split && !SPLIT_EN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = illegal ? ERR : BEAT0;
            BEAT0: if (hs)     state_nxt = split_q ? BEAT1 : IDLE;
            BEAT1: if (hs)     state_nxt = IDLE;
            ERR:               state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= '0;
            err_addr  <= '0;
            b1_addr   <= '0;
            b1_data   <= '0;
            b1_we     <= '0;
            split_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            err_addr <= req_addr;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_addr  <= base;
                            mem_wdata <= ext[DW-1:0];
                            mem_we    <= s[NB-1:0];
                            b1_addr   <= base + AW'(NB);  // wraps modulo 2^AW
                            b1_data   <= ext[2*DW-1:DW];
                            b1_we     <= s[2*NB-1:NB];
                            split_q   <= split;
                        end
                    end
                end
                BEAT0: begin
                    if (hs) begin
                        if (split_q) begin
                            mem_addr  <= b1_addr;
                            mem_wdata <= b1_data;
                            mem_we    <= b1_we;
                        end else begin
                            mem_valid <= 1'b0;
                        end
                    end
                end
                BEAT1: begin
                    if (hs) mem_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_store_lane_aligner.sv
module tb_store_lane_aligner;
    logic clk;
    logic rst;

    // a: DW=32 SPLIT_EN=1, b: DW=32 SPLIT_EN=0, c: DW=64 SPLIT_EN=1
    logic        req_valid_a, req_ready_a, mem_valid_a, mem_ready_a, err_valid_a, busy_a;
    logic [31:0] req_addr_a, req_data_a, mem_addr_a, mem_wdata_a, err_addr_a;
    logic [1:0]  req_size_a;
    logic [3:0]  mem_we_a;

    logic        req_valid_b, req_ready_b, mem_valid_b, mem_ready_b, err_valid_b, busy_b;
    logic [31:0] req_addr_b, req_data_b, mem_addr_b, mem_wdata_b, err_addr_b;
    logic [1:0]  req_size_b;
    logic [3:0]  mem_we_b;

    logic        req_valid_c, req_ready_c, mem_valid_c, mem_ready_c, err_valid_c, busy_c;
    logic [31:0] req_addr_c, mem_addr_c, err_addr_c;
    logic [63:0] req_data_c, mem_wdata_c;
    logic [1:0]  req_size_c;
    logic [7:0]  mem_we_c;

    int n_vec = 0;
    int n_bad = 0;

    store_lane_aligner #(.DW(32), .AW(32), .SPLIT_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_addr(req_addr_a), .req_data(req_data_a), .req_size(req_size_a),
        .mem_valid(mem_valid_a), .mem_ready(mem_ready_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .err_valid(err_valid_a),
        .err_addr(err_addr_a), .busy(busy_a));

    store_lane_aligner #(.DW(32), .AW(32), .SPLIT_EN(1'b0)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr_b), .req_data(req_data_b), .req_size(req_size_b),
        .mem_valid(mem_valid_b), .mem_ready(mem_ready_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .err_valid(err_valid_b),
        .err_addr(err_addr_b), .busy(busy_b));

    store_lane_aligner #(.DW(64), .AW(32), .SPLIT_EN(1'b1)) u_c (
        .clk(clk), .rst(rst), .req_valid(req_valid_c), .req_ready(req_ready_c),
        .req_addr(req_addr_c), .req_data(req_data_c), .req_size(req_size_c),
        .mem_valid(mem_valid_c), .mem_ready(mem_ready_c), .mem_addr(mem_addr_c),
        .mem_wdata(mem_wdata_c), .mem_we(mem_we_c), .err_valid(err_valid_c),
        .err_addr(err_addr_c), .busy(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one request on unit a at a negedge, let it be accepted, then scramble inputs.
    task automatic store_a(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        req_addr_a  = addr;
        req_data_a  = data;
        req_size_a  = size;
        req_valid_a = 1'b1;
        chk("a_ready_pre", {63'd0, req_ready_a}, 64'd1);
        step();
        req_valid_a = 1'b0;
        req_addr_a  = 32'h5555_5555;
        req_data_a  = 32'hFFFF_FFFF;
        req_size_a  = 2'b11;
    endtask

    task automatic beat_a(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] we);
        chk({tag, "_vld"},   {63'd0, mem_valid_a}, 64'd1);
        chk({tag, "_addr"},  {32'd0, mem_addr_a},  {32'd0, addr});
        chk({tag, "_wdata"}, {32'd0, mem_wdata_a}, {32'd0, data});
        chk({tag, "_we"},    {60'd0, mem_we_a},    {60'd0, we});
    endtask

    task automatic idle_a(input string tag);
        chk({tag, "_vld0"}, {63'd0, mem_valid_a}, 64'd0);
        chk({tag, "_rdy1"}, {63'd0, req_ready_a}, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_a = 0; req_addr_a = 0; req_data_a = 0; req_size_a = 0; mem_ready_a = 1;
        req_valid_b = 0; req_addr_b = 0; req_data_b = 0; req_size_b = 0; mem_ready_b = 1;
        req_valid_c = 0; req_addr_c = 0; req_data_c = 0; req_size_c = 0; mem_ready_c = 1;

        @(negedge clk);
        chk("rst_vld",   {63'd0, mem_valid_a}, 64'd0);
        chk("rst_rdy",   {63'd0, req_ready_a}, 64'd0);
        chk("rst_busy",  {63'd0, busy_a},      64'd0);
        chk("rst_err",   {63'd0, err_valid_a}, 64'd0);
        chk("rst_addr",  {32'd0, mem_addr_a},  64'd0);
        chk("rst_we",    {60'd0, mem_we_a},    64'd0);
        chk("rst_eaddr", {32'd0, err_addr_a},  64'd0);
        rst = 1'b0;
        #1 chk("rst_rel_rdy", {63'd0, req_ready_a}, 64'd1);
        @(negedge clk);

        // Aligned word.
        store_a(32'h100, 32'hDEAD_BEEF, 2'b10);
        beat_a("word", 32'h100, 32'hDEAD_BEEF, 4'b1111);
        chk("word_rdy0", {63'd0, req_ready_a}, 64'd0);
        chk("word_busy", {63'd0, busy_a},      64'd1);
        step();
        idle_a("word_done");

        // Byte to top lane, then half to upper two lanes.
        store_a(32'h103, 32'h0000_00A5, 2'b00);
        beat_a("byte", 32'h100, 32'hA500_0000, 4'b1000);
        step();
        idle_a("byte_done");
        store_a(32'h102, 32'h0000_BEEF, 2'b01);
        beat_a("half", 32'h100, 32'hBEEF_0000, 4'b1100);
        step();
        idle_a("half_done");

        // Split word with 3 cycles of backpressure on beat0, reset during beat1.
        mem_ready_a = 1'b0;
        store_a(32'h102, 32'h1122_3344, 2'b10);
        beat_a("sp_b0", 32'h100, 32'h3344_0000, 4'b1100);
        for (int k = 0; k < 3; k++) begin
            step();
            beat_a("sp_hold", 32'h100, 32'h3344_0000, 4'b1100);
            chk("sp_hold_rdy",  {63'd0, req_ready_a}, 64'd0);
            chk("sp_hold_busy", {63'd0, busy_a},      64'd1);
        end
        mem_ready_a = 1'b1;
        step();
        beat_a("sp_b1", 32'h104, 32'h0000_1122, 4'b0011);
        mem_ready_a = 1'b0;
        step();
        beat_a("sp_b1_hold", 32'h104, 32'h0000_1122, 4'b0011);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld",  {63'd0, mem_valid_a}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy_a},      64'd0);
        chk("mid_rst_rdy",  {63'd0, req_ready_a}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready_a = 1'b1;
        step();
        idle_a("post_rst");

        // Split across the top of the address space.
        store_a(32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b10);
        beat_a("wrap_b0", 32'hFFFF_FFFC, 32'hCCDD_0000, 4'b1100);
        step();
        beat_a("wrap_b1", 32'h0000_0000, 32'h0000_AABB, 4'b0011);
        chk("wrap_noerr", {63'd0, err_valid_a}, 64'd0);
        step();
        idle_a("wrap_done");

        // Dword on a 32-bit unit is rejected.
        store_a(32'h0000_0040, 32'h1234_5678, 2'b11);
        chk("dw32_err",   {63'd0, err_valid_a}, 64'd1);
        chk("dw32_eaddr", {32'd0, err_addr_a},  64'h40);
        chk("dw32_vld",   {63'd0, mem_valid_a}, 64'd0);
        step();
        chk("dw32_err_end", {63'd0, err_valid_a}, 64'd0);
        idle_a("dw32_done");

        // Split disabled: crossing half errors, aligned word still issues.
        req_addr_b = 32'h003; req_data_b = 32'h0000_BEEF; req_size_b = 2'b01; req_valid_b = 1'b1;
        step();
        req_valid_b = 1'b0;
        chk("ns_err",   {63'd0, err_valid_b}, 64'd1);
        chk("ns_eaddr", {32'd0, err_addr_b},  64'h3);
        chk("ns_vld",   {63'd0, mem_valid_b}, 64'd0);
        step();
        chk("ns_err_end", {63'd0, err_valid_b}, 64'd0);
        chk("ns_vld2",    {63'd0, mem_valid_b}, 64'd0);
        chk("ns_eaddr_held", {32'd0, err_addr_b}, 64'h3);
        req_addr_b = 32'h004; req_data_b = 32'hCAFE_F00D; req_size_b = 2'b10; req_valid_b = 1'b1;
        step();
        req_valid_b = 1'b0;
        chk("ns_word_vld",   {63'd0, mem_valid_b}, 64'd1);
        chk("ns_word_addr",  {32'd0, mem_addr_b},  64'h4);
        chk("ns_word_wdata", {32'd0, mem_wdata_b}, 64'hCAFE_F00D);
        chk("ns_word_we",    {60'd0, mem_we_b},    64'hF);
        step();

        // 64-bit unit: aligned dword, then word into upper half.
        req_addr_c = 32'h8; req_data_c = 64'h0123_4567_89AB_CDEF; req_size_c = 2'b11; req_valid_c = 1'b1;
        step();
        req_valid_c = 1'b0;
        chk("dw64_vld",   {63'd0, mem_valid_c}, 64'd1);
        chk("dw64_addr",  {32'd0, mem_addr_c},  64'h8);
        chk("dw64_wdata", mem_wdata_c,          64'h0123_4567_89AB_CDEF);
        chk("dw64_we",    {56'd0, mem_we_c},    64'hFF);
        step();
        chk("dw64_done", {63'd0, mem_valid_c}, 64'd0);
        req_addr_c = 32'hC; req_data_c = 64'hFFFF_FFFF_1357_9BDF; req_size_c = 2'b10; req_valid_c = 1'b1;
        step();
        req_valid_c = 1'b0;
        chk("w64_addr",  {32'd0, mem_addr_c}, 64'h8);
        chk("w64_wdata", mem_wdata_c,         64'h1357_9BDF_0000_0000);
        chk("w64_we",    {56'd0, mem_we_c},   64'hF0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
